// File: rtl/pkt_link_pkg.sv
// Shared framing constants, FSM states and word helpers for the GTX link packet TX/RX pair.
// Pure definitions: no logic and no timing.
package pkt_link_pkg;

  localparam logic [7:0]  K_HEADER  = 8'hBC;
  localparam logic [31:0] IDLE_WORD = 32'h0000_0000;
  localparam logic [3:0]  HDR_CTRL  = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SEQ,
    CTRL,
    DATA,
    CHECK,
    GAP
  } pkt_state_t;

  function automatic logic [31:0] ctrl_word(input logic [15:0] len, input logic [7:0] typ);
    return {len, 8'h00, typ};
  endfunction

endpackage

// File: rtl/packet_gen_if.sv
// Control inputs and TX word stream of the link packet generator.
// master = generator side, slave = stimulus/receiver side; no flow control on the stream.
interface packet_gen_if;

  logic        enable_i;
  logic [15:0] packet_len_i;
  logic [7:0]  packet_type_i;
  logic        err_inject_i;
  logic [31:0] gt_tx_data;
  logic [3:0]  gt_tx_ctrl;
  logic        busy_o;
  logic [31:0] packet_cnt_o;

  modport master (
    input  enable_i, packet_len_i, packet_type_i, err_inject_i,
    output gt_tx_data, gt_tx_ctrl, busy_o, packet_cnt_o
  );

  modport slave (
    output enable_i, packet_len_i, packet_type_i, err_inject_i,
    input  gt_tx_data, gt_tx_ctrl, busy_o, packet_cnt_o
  );

endinterface

// File: rtl/pkt_checksum_acc.sv
// 32-bit modular checksum accumulator; sum_next is the combinational value the register takes next.
// Zero latency on sum_next, no backpressure.
module pkt_checksum_acc (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] sum_next
);

  logic [31:0] sum_q;

  always_comb begin
    sum_next = sum_q;
    if (clr) begin
      sum_next = '0;
    end else if (add_en) begin
      sum_next = sum_q + add_val;
    end
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_next;
    end
  end

endmodule

// File: rtl/packet_gen.sv
// GTX TX link-test packet generator: header, seq, control, payload, checksum, idle gap.
// One registered word per clock, 1-cycle latency; no backpressure, enable_i only gates frame starts.
module packet_gen
  import pkt_link_pkg::*;
#(
  parameter int          GAP_WORDS = 4,
  parameter logic [15:0] DATA_SEED = 16'h0
) (
  input logic          rx_clk,
  input logic          rst,
  packet_gen_if.master bus
);

  localparam int          GAP_EFF  = (GAP_WORDS < 1) ? 1 : GAP_WORDS;
  localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);

  pkt_state_t  state;
  logic [15:0] len_q;
  logic [7:0]  type_q;
  logic        corrupt_q;
  logic        err_pending;
  logic [31:0] seq;
  logic [15:0] dcnt;
  logic [15:0] gcnt;
  logic [31:0] payload_word;
  logic [31:0] sum_next;

  assign payload_word = {seq[15:0], DATA_SEED + dcnt};

  // In CHECK neither clear nor add is active, so sum_next already holds the full payload sum.
  pkt_checksum_acc u_acc (
    .rx_clk   (rx_clk),
    .rst      (rst),
    .clr      (state == CTRL),
    .add_en   (state == DATA),
    .add_val  (payload_word),
    .sum_next (sum_next)
  );

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.gt_tx_data   <= IDLE_WORD;
      bus.gt_tx_ctrl   <= 4'h0;
      bus.busy_o       <= 1'b0;
      bus.packet_cnt_o <= '0;
      seq              <= '0;
      len_q            <= 16'd1;
      type_q           <= '0;
      corrupt_q        <= 1'b0;
      err_pending      <= 1'b0;
      dcnt             <= '0;
      gcnt             <= '0;
    end else begin
      bus.gt_tx_data <= IDLE_WORD;
      bus.gt_tx_ctrl <= 4'h0;
      bus.busy_o     <= 1'b0;

      // Pulses not consumed by a frame start are held for the next frame.
      if (state == IDLE && bus.enable_i) begin
        err_pending <= 1'b0;
      end else if (bus.err_inject_i) begin
        err_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.enable_i) begin
            state     <= HEADER;
            len_q     <= (bus.packet_len_i == 16'd0) ? 16'd1 : bus.packet_len_i;
            type_q    <= bus.packet_type_i;
            corrupt_q <= err_pending | bus.err_inject_i;
          end
        end
        HEADER: begin
          bus.gt_tx_data <= {24'h0, K_HEADER};
          bus.gt_tx_ctrl <= HDR_CTRL;
          bus.busy_o     <= 1'b1;
          state          <= SEQ;
        end
        SEQ: begin
          bus.gt_tx_data <= seq;
          bus.busy_o     <= 1'b1;
          state          <= CTRL;
        end
        CTRL: begin
          bus.gt_tx_data <= ctrl_word(len_q, type_q);
          bus.busy_o     <= 1'b1;
          dcnt           <= 16'd1;
          state          <= DATA;
        end
        DATA: begin
          bus.gt_tx_data <= payload_word;
          bus.busy_o     <= 1'b1;
          dcnt           <= dcnt + 16'd1;
          if (dcnt == len_q) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          bus.gt_tx_data   <= corrupt_q ? ~sum_next : sum_next;
          bus.busy_o       <= 1'b1;
          bus.packet_cnt_o <= bus.packet_cnt_o + 32'd1;
          seq              <= seq + 32'd1;
          gcnt             <= '0;
          state            <= GAP;
        end
        GAP: begin
          gcnt <= gcnt + 16'd1;
          if (gcnt == GAP_LAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
